// File: rtl/usb_tr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : usb_tr_scheduler
// Description : Round-robin transaction scheduler for a 4-port USB hub
//               transceiver. It grants one downstream port at a time, follows
//               the transceiver through drive and response phases with a
//               response timeout, enforces an inter-transaction hold-off, and
//               generates polling ticks while the bus is idle.
// Ports       : clk                    - sole clock, rising edge
//               rst_n                  - asynchronous active-low reset
//               i_port_req[3:0]        - per-port packet pending
//               i_driving_req          - transceiver is driving the bus
//               i_serial_data_out_val  - transceiver is decoding response bits
//               o_grant[3:0]           - one-hot grant, zero when no owner
//               o_grant_id[1:0]        - index of last granted port
//               o_serial_data_in_avail - data-available to transceiver
//               o_polling_clock        - single-cycle polling tick
//               o_txn_done             - single-cycle response-received pulse
//               o_txn_timeout          - single-cycle abandoned pulse
//               o_busy                 - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tr_scheduler #(
  parameter int POLL_PERIOD  = 1000,
  parameter int RESP_TIMEOUT = 64,
  parameter int HOLDOFF      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_port_req,
  input  logic       i_driving_req,
  input  logic       i_serial_data_out_val,
  output logic [3:0] o_grant,
  output logic [1:0] o_grant_id,
  output logic       o_serial_data_in_avail,
  output logic       o_polling_clock,
  output logic       o_txn_done,
  output logic       o_txn_timeout,
  output logic       o_busy
);

  localparam logic [15:0] C_POLL_LAST = 16'(POLL_PERIOD - 1);
  localparam logic [7:0]  C_TO_LAST   = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0]  C_HOLD_LAST = 8'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_DRIVE = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_to_cnt;
  logic [15:0] r_poll_cnt;
  logic [1:0]  r_last_grant;

  logic        w_pick_vld;
  logic [1:0]  w_pick_id;
  logic [1:0]  w_cand;
  logic [1:0]  w_id_nxt;
  logic        w_owning_nxt;
  logic [3:0]  w_grant_nxt;
  logic        w_avail_nxt;
  logic        w_poll_nxt;
  logic        w_done_nxt;
  logic        w_timeout_nxt;

  // Round-robin pick: scan the four ports starting one past the last owner.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = r_last_grant;
    w_cand     = r_last_grant;
    for (int i = 1; i <= 4; i++) begin
      w_cand = r_last_grant + 2'(i);
      if (!w_pick_vld && i_port_req[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = w_cand;
      end
    end
  end

  // Next-state and pulse decode. In RESP the response check precedes the
  // timeout check so a coincident response reports done, never timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (i_driving_req) begin
          w_state_nxt = S_DRIVE;
        end else if (!i_port_req[o_grant_id]) begin
          w_state_nxt = S_GAP;
        end else if (r_to_cnt >= C_TO_LAST) begin
          w_state_nxt   = S_GAP;
          w_timeout_nxt = 1'b1;
        end
      end
      S_DRIVE: begin
        if (!i_driving_req) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (i_serial_data_out_val) begin
          w_state_nxt = S_GAP;
          w_done_nxt  = 1'b1;
        end else if (r_to_cnt >= C_TO_LAST) begin
          w_state_nxt   = S_GAP;
          w_timeout_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (r_to_cnt >= C_HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered-output precompute, derived from the next state so outputs
  // line up with the state they describe.
  always_comb begin
    w_id_nxt     = (r_state == S_IDLE && w_pick_vld) ? w_pick_id : o_grant_id;
    w_owning_nxt = (w_state_nxt == S_GRANT) || (w_state_nxt == S_DRIVE) ||
                   (w_state_nxt == S_RESP);
    w_grant_nxt  = w_owning_nxt ? (4'b0001 << w_id_nxt) : 4'b0000;
    w_avail_nxt  = ((w_state_nxt == S_GRANT) || (w_state_nxt == S_DRIVE)) ?
                   i_port_req[w_id_nxt] : 1'b0;
    // A tick that lands while busy or while a request is pending is simply lost.
    w_poll_nxt   = (r_state == S_IDLE) && (i_port_req == 4'b0000) &&
                   (r_poll_cnt == C_POLL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt               <= 8'd0;
      r_poll_cnt             <= 16'd0;
      r_last_grant           <= 2'd3;
      o_grant                <= 4'b0000;
      o_grant_id             <= 2'd0;
      o_serial_data_in_avail <= 1'b0;
      o_polling_clock        <= 1'b0;
      o_txn_done             <= 1'b0;
      o_txn_timeout          <= 1'b0;
      o_busy                 <= 1'b0;
    end else begin
      // Phase timer restarts on every state change and sticks at all-ones.
      if (w_state_nxt != r_state) begin
        r_to_cnt <= 8'd0;
      end else if (r_to_cnt != 8'hFF) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end

      if (r_poll_cnt >= C_POLL_LAST) begin
        r_poll_cnt <= 16'd0;
      end else begin
        r_poll_cnt <= r_poll_cnt + 16'd1;
      end

      if (r_state == S_IDLE && w_state_nxt == S_GRANT) begin
        r_last_grant <= w_pick_id;
      end

      o_grant                <= w_grant_nxt;
      o_grant_id             <= w_id_nxt;
      o_serial_data_in_avail <= w_avail_nxt;
      o_polling_clock        <= w_poll_nxt;
      o_txn_done             <= w_done_nxt;
      o_txn_timeout          <= w_timeout_nxt;
      o_busy                 <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_tr_scheduler
// Description : Self-checking bench for usb_tr_scheduler: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tr_scheduler;

  localparam int P  = 8;
  localparam int TO = 64;
  localparam int HO = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_GRANT = 1;
  localparam int PH_DRIVE = 2;
  localparam int PH_RESP  = 3;
  localparam int PH_GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pr;
  logic       dr;
  logic       sv;
  logic [3:0] o_grant;
  logic [1:0] o_grant_id;
  logic       o_avail;
  logic       o_poll;
  logic       o_done;
  logic       o_to;
  logic       o_busy;
  logic [10:0] w_out;

  int errors = 0;
  int checks = 0;

  usb_tr_scheduler #(
    .POLL_PERIOD (P),
    .RESP_TIMEOUT(TO),
    .HOLDOFF     (HO)
  ) u_dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_port_req            (pr),
    .i_driving_req         (dr),
    .i_serial_data_out_val (sv),
    .o_grant               (o_grant),
    .o_grant_id            (o_grant_id),
    .o_serial_data_in_avail(o_avail),
    .o_polling_clock       (o_poll),
    .o_txn_done            (o_done),
    .o_txn_timeout         (o_to),
    .o_busy                (o_busy)
  );

  always #5 clk = ~clk;

  // {grant, grant_id, avail, poll, done, timeout, busy}
  assign w_out = {o_grant, o_grant_id, o_avail, o_poll, o_done, o_to, o_busy};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pr = 4'b0000;
    dr = 1'b0;
    sv = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [10:0] pack(input logic [3:0] g, input logic [1:0] id,
                                       input logic av, input logic poll,
                                       input logic done, input logic to,
                                       input logic busy);
    return {g, id, av, poll, done, to, busy};
  endfunction

  // ---------------- behavioural reference model ----------------
  int m_phase, m_t, m_last, m_owner, m_pcnt;
  logic [10:0] m_exp;

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_t     = 0;
    m_last  = 3;
    m_owner = 0;
    m_pcnt  = 0;
    m_exp   = '0;
  endtask

  task automatic model_step(input logic [3:0] p, input logic d, input logic s);
    int   np;
    logic done, to, poll, av;
    logic [3:0] g;
    poll   = (m_pcnt == P - 1) && (m_phase == PH_IDLE) && (p == 4'b0000);
    m_pcnt = (m_pcnt + 1) % P;
    np   = m_phase;
    done = 1'b0;
    to   = 1'b0;
    if (m_phase == PH_IDLE) begin
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last + i) % 4;
        if (np == PH_IDLE && p[c]) begin
          np = PH_GRANT;
          m_owner = c;
          m_last = c;
        end
      end
    end else if (m_phase == PH_GRANT) begin
      if (d) np = PH_DRIVE;
      else if (!p[m_owner]) np = PH_GAP;
      else if (m_t == TO - 1) begin np = PH_GAP; to = 1'b1; end
    end else if (m_phase == PH_DRIVE) begin
      if (!d) np = PH_RESP;
    end else if (m_phase == PH_RESP) begin
      if (s) begin np = PH_GAP; done = 1'b1; end
      else if (m_t == TO - 1) begin np = PH_GAP; to = 1'b1; end
    end else begin
      if (m_t == HO - 1) np = PH_IDLE;
    end
    m_t = (np != m_phase) ? 0 : ((m_t < 255) ? m_t + 1 : 255);
    m_phase = np;
    g  = (np >= PH_GRANT && np <= PH_RESP) ? 4'(1 << m_owner) : 4'b0000;
    av = (np == PH_GRANT || np == PH_DRIVE) ? p[m_owner] : 1'b0;
    m_exp = pack(g, 2'(m_owner), av, poll, done, to, np != PH_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  pr;
    logic        dr;
    logic        sv;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] p, input logic d, input logic s,
                     input logic [10:0] e);
    vec_t v;
    v.pr = p; v.dr = d; v.sv = s; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic resp_timeout_case(input bit with_sv);
    do_reset();
    pr = 4'b0001;
    tick();
    dr = 1'b1;
    tick();
    dr = 1'b0;
    tick();
    chk("resp_entry", w_out, pack(4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int n = 4; n <= 67; n++) begin
      sv = (n == 67) && with_sv;
      tick();
      if (n == 67) begin
        chk(with_sv ? "resp_coincide_done" : "resp_timeout_done", o_done, with_sv);
        chk(with_sv ? "resp_coincide_to" : "resp_timeout_to", o_to, !with_sv);
      end else if (o_done || o_to || !o_busy) begin
        chk("resp_wait", {o_done, o_to, o_busy}, 3'b001);
      end
    end
    sv = 1'b0;
    tick();
    chk("resp_pulse_one_cycle", {o_done, o_to}, 2'b00);
  endtask

  initial begin
    logic [3:0] g;
    int id;

    // ---- reset state ----
    do_reset();
    chk("reset_outputs", w_out, 11'd0);

    // ---- round robin with all ports requesting ----
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      g  = 4'(1 << id);
      add(4'hF, 1'b0, 1'b0, pack(g, 2'(id), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b1, 1'b0, pack(g, 2'(id), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b1, 1'b0, pack(g, 2'(id), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b1, 1'b0, pack(g, 2'(id), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b0, 1'b0, pack(g, 2'(id), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b0, 1'b1, pack(4'b0, 2'(id), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      add(4'hF, 1'b0, 1'b0, pack(4'b0, 2'(id), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      add(4'hF, 1'b0, 1'b0, pack(4'b0, 2'(id), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    for (int i = 0; i < tbl.size(); i++) begin
      pr = tbl[i].pr;
      dr = tbl[i].dr;
      sv = tbl[i].sv;
      tick();
      chk($sformatf("vec%0d", i), w_out, tbl[i].exp);
    end

    // ---- polling ticks, then a request across a tick ----
    do_reset();
    for (int n = 1; n <= 39; n++) begin
      tick();
      chk($sformatf("poll_c%0d", n), o_poll, (n % 8) == 0);
    end
    pr = 4'b0100;
    tick();
    chk("poll_suppressed", o_poll, 1'b0);
    chk("poll_req_grant", o_grant, 4'b0100);
    chk("poll_req_id", o_grant_id, 2'd2);

    // ---- grant without driving_req times out ----
    do_reset();
    pr = 4'b0010;
    for (int n = 1; n <= 70; n++) begin
      tick();
      if (n == 1) chk("gto_grant", o_grant, 4'b0010);
      chk($sformatf("gto_pulse_c%0d", n), o_to, n == 65);
      if (n >= 65) begin
        pr = 4'b0000;
        chk($sformatf("gto_busy_c%0d", n), {o_grant, o_busy}, {4'b0000, n <= 66});
      end
    end
    chk("gto_id_held", o_grant_id, 2'd1);

    // ---- response timeout and coincidence ----
    resp_timeout_case(1'b1);
    resp_timeout_case(1'b0);

    // ---- request withdrawn in GRANT ----
    do_reset();
    pr = 4'b0001;
    tick();
    pr = 4'b0000;
    tick();
    chk("withdraw_gap", w_out, pack(4'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    // ---- reset during DRIVE ----
    do_reset();
    pr = 4'b1000;
    tick();
    dr = 1'b1;
    tick();
    chk("drive_before_rst", w_out, pack(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", w_out, 11'd0);
    dr = 1'b0;
    sv = 1'b1;
    tick();
    chk("rst_no_pulse", w_out, 11'd0);
    sv = 1'b0;
    pr = 4'b0110;
    rst_n = 1'b1;
    tick();
    chk("post_rst_grant", {o_grant, o_grant_id}, {4'b0010, 2'd1});

    // ---- request dropped in DRIVE ----
    do_reset();
    pr = 4'b0100;
    tick();
    dr = 1'b1;
    tick();
    chk("drop_drive_avail", o_avail, 1'b1);
    pr = 4'b0000;
    tick();
    chk("drop_avail_low", w_out, pack(4'b0100, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    chk("drop_still_drive", {o_grant, o_avail, o_busy}, {4'b0100, 1'b0, 1'b1});
    dr = 1'b0;
    tick();
    chk("drop_resp", {o_grant, o_avail, o_busy}, {4'b0100, 1'b0, 1'b1});

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        pr = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      end
      dr = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 3) == 0);
      tick();
      model_step(pr, dr, sv);
      if (w_out !== m_exp) begin
        chk($sformatf("rand_c%0d", n), w_out, m_exp);
      end else begin
        checks++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
